cdc_handshake_tx: RTL and testbench

//   Source end of a two-phase (toggle) req/ack crossing for multi-bit words.

---
 rtl/cdc_handshake_tx.sv | 145 ++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase (toggle) req/ack word crossing.
// Holds a word on xfer_data and waits for the resynchronised ack toggle.
module cdc_handshake_tx #(
  parameter int Width  = 8,
  parameter int Stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             ack_in,
  output logic             done,
  output logic [15:0]      sent_count,
  output logic             proto_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_req;
  logic [Width-1:0] r_data;
  logic             r_done;
  logic [15:0]      r_cnt;
  logic             r_err;

  logic w_ack_sync;
  logic w_match;
  logic w_accept;
  logic w_ack_done;
  logic w_idle_err;

  // Ack resynchroniser; depth 0 bypasses it for loopback simulation.
  generate
    if (Stages == 0) begin : g_nosync
      assign w_ack_sync = ack_in;
    end else begin : g_sync
      logic [Stages-1:0] r_sync;

      // Shift the raw ack toggle through the flop chain.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= ack_in;
          for (int i = 1; i < Stages; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_ack_sync = r_sync[Stages-1];
    end
  endgenerate

  // Far side has caught up when its ack level equals our req level.
  assign w_match    = (w_ack_sync == r_req);
  assign w_idle_err = (r_state == ST_IDLE) && !w_match;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transfer events.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_match) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the word and flip the request level on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_req  <= 1'b0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_req  <= ~r_req;
    end
  end

  // One-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_ack_done;
    end
  end

  // Count acknowledged words, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_ack_done) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Sticky flag: ack moved while nothing was outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_idle_err) begin
      r_err <= 1'b1;
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign xfer_data  = r_data;
  assign xfer_req   = r_req;
  assign done       = r_done;
  assign sent_count = r_cnt;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed steps plus a random
// phase, all checked against a transaction-level model.
module tb_cdc_handshake_tx;

  localparam int STG = 2;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  xfer_data;
  logic        xfer_req;
  logic        ack_in;
  logic        done;
  logic [15:0] sent_count;
  logic        proto_err;

  cdc_handshake_tx #(.Width(8), .Stages(STG)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xfer_data  (xfer_data),
    .xfer_req   (xfer_req),
    .ack_in     (ack_in),
    .done       (done),
    .sent_count (sent_count),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit lb = 1'b0;

  bit         m_busy;
  bit         m_req;
  bit         m_done;
  bit         m_err;
  bit [7:0]   m_data;
  bit [15:0]  m_cnt;
  bit         m_ackq[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver's ack is seen STG clocks late; compare with the
  // outstanding request level to decide what happens this edge.
  task automatic model_edge();
    bit as;
    if (reset) begin
      m_busy = 0; m_req = 0; m_done = 0; m_err = 0;
      m_data = 0; m_cnt = 0;
      m_ackq.delete();
      for (int i = 0; i < STG; i++) m_ackq.push_back(1'b0);
    end else begin
      as = (STG == 0) ? ack_in : m_ackq[0];
      m_done = 0;
      if (!m_busy) begin
        if (as != m_req) m_err = 1;
        if (in_valid) begin
          m_data = in_data;
          m_req  = ~m_req;
          m_busy = 1;
        end
      end else if (as == m_req) begin
        m_busy = 0;
        m_done = 1;
        m_cnt  = m_cnt + 16'd1;
      end
      if (STG > 0) begin
        void'(m_ackq.pop_front());
        m_ackq.push_back(ack_in);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (lb) ack_in = m_req;
    chk("m_ready", in_ready, !m_busy);
    chk("m_req", xfer_req, m_req);
    chk("m_data", xfer_data, m_data);
    chk("m_done", done, m_done);
    chk("m_cnt", sent_count, m_cnt);
    chk("m_err", proto_err, m_err);
  endtask

  initial begin
    int ndone;
    int rcv;
    reset = 1; in_valid = 0; in_data = 0; ack_in = 0;

    // reset for three cycles
    repeat (3) step();
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", sent_count, 0);
    chk("rst_err", proto_err, 0);
    reset = 0;
    chk("rst_ready", in_ready, 1);

    // single word in loopback
    lb = 1;
    in_valid = 1; in_data = 8'hA5;
    step();
    in_valid = 0;
    chk("t2_req", xfer_req, 1);
    chk("t2_data", xfer_data, 8'hA5);
    chk("t2_rdy0", in_ready, 0);
    step();
    chk("t2_rdy1", in_ready, 0);
    step();
    chk("t2_rdy2", in_ready, 0);
    chk("t2_nodone", done, 0);
    step();
    chk("t2_done", done, 1);
    chk("t2_cnt", sent_count, 1);
    step();
    chk("t2_pulse", done, 0);

    // back-to-back words, valid held high
    reset = 1; step(); reset = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = 8'(k + 1);
      step();
      chk("t3_req", xfer_req, (k % 2 == 0));
      chk("t3_data", xfer_data, k + 1);
      chk("t3_busy", in_ready, 0);
      step(); step(); step();
      chk("t3_done", done, 1);
    end
    in_valid = 0;
    chk("t3_cnt", sent_count, 4);
    chk("t3_err", proto_err, 0);

    // slow receiver, noisy inputs while waiting
    lb = 0;
    in_valid = 1; in_data = 8'h3C;
    step();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      step();
      chk("t4_hold", xfer_data, 8'h3C);
      chk("t4_wait", done, 0);
    end
    in_valid = 0;
    ack_in = 1;
    ndone = 0;
    step(); ndone += int'(done);
    step(); ndone += int'(done);
    chk("t4_early", ndone, 0);
    step();
    chk("t4_done", done, 1);
    ndone += int'(done);
    step(); ndone += int'(done);
    step(); ndone += int'(done);
    chk("t4_once", ndone, 1);

    // stray ack toggle while idle
    ack_in = 0;
    step(); chk("t5_e1", proto_err, 0);
    step(); chk("t5_e2", proto_err, 0);
    step(); chk("t5_e3", proto_err, 1);
    ack_in = 1;
    repeat (3) step();
    lb = 1;
    in_valid = 1; in_data = 8'h5A;
    step();
    in_valid = 0;
    repeat (3) step();
    chk("t5_xdone", done, 1);
    chk("t5_sticky", proto_err, 1);

    // reset in the middle of a transfer
    in_valid = 1; in_data = 8'h77;
    step();
    in_valid = 0;
    chk("t6_pre", xfer_req, 1);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("t6_ready", in_ready, 1);
    chk("t6_req", xfer_req, 0);
    chk("t6_cnt", sent_count, 0);
    chk("t6_done", done, 0);
    chk("t6_err", proto_err, 0);
    repeat (4) step();

    // random traffic with a random-latency receiver
    lb = 0; rcv = 0;
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 800; c++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      step();
      if (ack_in != m_req) begin
        if (rcv == 0) begin
          ack_in = m_req;
          rcv = $urandom_range(0, 6);
        end else begin
          rcv--;
        end
      end
    end
    chk("rnd_noerr", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
